noc_input_ctrl: RTL and testbench



---
 rtl/noc_input_ctrl.sv | 121 ++++++++++++
 tb/tb_noc_input_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_ctrl.sv
// Router input-port controller: drains the input FIFO, XY-routes each packet's head flit,
// requests a one-hot output port and streams the packet through a one-entry hold register.
module noc_input_ctrl #(
    parameter int DATA_W   = 8,
    parameter int COORD_W  = 2,
    parameter int ROUTER_X = 1,
    parameter int ROUTER_Y = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] fifo_data_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    output logic [4:0]        out_req_o,
    input  logic              out_grant_i,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] flit_o,
    output logic              flit_valid_o,
    output logic              drop_o
);

    typedef enum logic [1:0] {IDLE, REQ, FWD} state_t;

    localparam logic [4:0] PORT_L = 5'b00001;
    localparam logic [4:0] PORT_N = 5'b00010;
    localparam logic [4:0] PORT_E = 5'b00100;
    localparam logic [4:0] PORT_S = 5'b01000;
    localparam logic [4:0] PORT_W = 5'b10000;

    localparam logic [COORD_W-1:0] HERE_X = COORD_W'(ROUTER_X);
    localparam logic [COORD_W-1:0] HERE_Y = COORD_W'(ROUTER_Y);

    state_t              state_q, state_d;
    logic [4:0]          req_q, req_d;
    logic [DATA_W-1:0]   hold_q;
    logic                hold_v, pend_v;
    logic [1:0]          hold_type;
    logic                is_head, is_tail;
    logic [COORD_W-1:0]  dest_x, dest_y;
    logic [4:0]          route;
    logic                transfer, consume;
    logic [1:0]          occupancy;

    // Type encoding: bit 0 marks a head (01/11), bit 1 marks a tail (10/11).
    assign hold_type = hold_q[DATA_W-1 -: 2];
    assign is_head   = hold_type[0];
    assign is_tail   = hold_type[1];
    assign dest_x    = hold_q[2*COORD_W-1:COORD_W];
    assign dest_y    = hold_q[COORD_W-1:0];

    assign transfer  = (state_q == FWD) && hold_v && out_ready_i;
    assign consume   = transfer || ((state_q == IDLE) && hold_v && !is_head);

    // Hold and in-flight slots are mutually exclusive, so occupancy never exceeds one.
    assign occupancy = {1'b0, hold_v} + {1'b0, pend_v} - {1'b0, consume};

    // NOTE: gated by rst_ni so the read strobe is quiet while reset is held, even with data waiting.
    assign fifo_rd_en_o = rst_ni && !fifo_empty_i && (occupancy == 2'd0);

    assign out_req_o    = req_q;
    assign flit_o       = hold_q;
    assign flit_valid_o = (state_q == FWD) && hold_v;
    assign drop_o       = (state_q == IDLE) && hold_v && !is_head;

    // XY routing: resolve X first, then Y, otherwise deliver locally.
    always_comb begin
        route = PORT_L;
        if (dest_x > HERE_X)      route = PORT_E;
        else if (dest_x < HERE_X) route = PORT_W;
        else if (dest_y > HERE_Y) route = PORT_N;
        else if (dest_y < HERE_Y) route = PORT_S;
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (hold_v && is_head) begin
                    req_d   = route;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (out_grant_i) state_d = FWD;
            end
            FWD: begin
                if (transfer && is_tail) begin
                    req_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= '0;
            hold_q  <= '0;
            hold_v  <= 1'b0;
            pend_v  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_v  <= fifo_rd_en_o;
            if (pend_v) begin
                hold_q <= fifo_data_i;
                hold_v <= 1'b1;
            end else if (consume) begin
                hold_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_input_ctrl.sv
// Directed bench for noc_input_ctrl: a small registered-read FIFO model feeds the DUT,
// and a monitor logs transfers, drops and reads for the per-scenario tasks to check.
module tb_noc_input_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] fifo_data = '0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [4:0] out_req;
    logic       out_grant = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] flit;
    logic       flit_valid;
    logic       drop;

    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr = '0;
    logic [3:0] rd_ptr = '0;

    logic [7:0] xfer_log [0:63];
    int         xfer_n = 0;
    int         drop_n = 0;
    int         rd_n = 0;
    int         underflow_n = 0;

    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk_i = ~clk_i;

    assign fifo_empty = (rd_ptr == wr_ptr);

    noc_input_ctrl #(.DATA_W(8), .COORD_W(2), .ROUTER_X(1), .ROUTER_Y(1)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .fifo_data_i (fifo_data),
        .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(fifo_rd_en),
        .out_req_o   (out_req),
        .out_grant_i (out_grant),
        .out_ready_i (out_ready),
        .flit_o      (flit),
        .flit_valid_o(flit_valid),
        .drop_o      (drop)
    );

    always @(posedge clk_i) begin
        if (fifo_rd_en) begin
            if (fifo_empty) underflow_n <= underflow_n + 1;
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 4'd1;
            rd_n      <= rd_n + 1;
        end
        if (flit_valid && out_ready) begin
            xfer_log[xfer_n[5:0]] <= flit;
            xfer_n <= xfer_n + 1;
        end
        if (drop) drop_n <= drop_n + 1;
    end

    task automatic push(input logic [7:0] f);
        mem[wr_ptr] = f;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++; if (out_req !== 5'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 00000", out_req); end
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", flit_valid); end
        n_checks++; if (flit !== 8'h00) begin n_fail++; $display("FAIL rst_flit: got %h exp 00", flit); end
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got %b exp 0", drop); end
        n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b exp 0", fifo_rd_en); end
        rst_ni = 1'b1;
        tick();
        n_checks++; if (fifo_rd_en !== 1'b0 || out_req !== 5'b0) begin n_fail++; $display("FAIL rst_idle: rd_en %b req %b exp 0 00000", fifo_rd_en, out_req); end
    endtask

    task automatic test_local();
        int rbase, xbase;
        rbase = rd_n; xbase = xfer_n;
        out_ready = 1'b1; out_grant = 1'b0;
        push(8'hC5);
        #1;
        n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL t1_rd_issue: got %b exp 1", fifo_rd_en); end
        tick();
        n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL t1_rd_pend: got %b exp 0", fifo_rd_en); end
        tick();
        n_checks++; if (out_req !== 5'b0 || flit_valid !== 1'b0) begin n_fail++; $display("FAIL t1_hold: req %b valid %b exp 00000 0", out_req, flit_valid); end
        tick();
        n_checks++; if (out_req !== 5'b00001) begin n_fail++; $display("FAIL t1_req: got %b exp 00001", out_req); end
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL t1_req_valid: got %b exp 0", flit_valid); end
        out_grant = 1'b1;
        tick();
        n_checks++; if (flit_valid !== 1'b1 || flit !== 8'hC5) begin n_fail++; $display("FAIL t1_fwd: valid %b flit %h exp 1 c5", flit_valid, flit); end
        n_checks++; if (out_req !== 5'b00001) begin n_fail++; $display("FAIL t1_fwd_req: got %b exp 00001", out_req); end
        tick();
        out_grant = 1'b0;
        n_checks++; if (out_req !== 5'b0 || flit_valid !== 1'b0) begin n_fail++; $display("FAIL t1_release: req %b valid %b exp 00000 0", out_req, flit_valid); end
        n_checks++; if (rd_n - rbase != 1) begin n_fail++; $display("FAIL t1_rd_count: got %0d exp 1", rd_n - rbase); end
        n_checks++; if (xfer_n - xbase != 1 || xfer_log[xbase[5:0]] !== 8'hC5) begin n_fail++; $display("FAIL t1_xfer: count %0d flit %h exp 1 c5", xfer_n - xbase, xfer_log[xbase[5:0]]); end
    endtask

    task automatic test_east();
        int xbase;
        logic [7:0] exp_f [3];
        exp_f[0] = 8'h49; exp_f[1] = 8'h0A; exp_f[2] = 8'h8B;
        xbase = xfer_n;
        out_ready = 1'b1; out_grant = 1'b1;
        push(8'h49); push(8'h0A); push(8'h8B);
        repeat (3) tick();
        n_checks++; if (out_req !== 5'b00100) begin n_fail++; $display("FAIL t2_req: got %b exp 00100", out_req); end
        for (int i = 0; i < 20 && (xfer_n - xbase) < 3; i++) begin
            tick();
            if ((xfer_n - xbase) < 3) begin
                n_checks++; if (out_req !== 5'b00100) begin n_fail++; $display("FAIL t2_req_stable: got %b exp 00100", out_req); end
            end
        end
        n_checks++; if (xfer_n - xbase != 3) begin n_fail++; $display("FAIL t2_count: got %0d exp 3", xfer_n - xbase); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (xfer_log[(xbase + i) % 64] !== exp_f[i]) begin n_fail++; $display("FAIL t2_order[%0d]: got %h exp %h", i, xfer_log[(xbase + i) % 64], exp_f[i]); end
        end
        n_checks++; if (out_req !== 5'b0) begin n_fail++; $display("FAIL t2_release: got %b exp 00000", out_req); end
        out_grant = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int  xbase;
        bit  found;
        logic [7:0] exp_f [3];
        exp_f[0] = 8'h49; exp_f[1] = 8'h0A; exp_f[2] = 8'h8B;
        xbase = xfer_n; found = 1'b0;
        out_ready = 1'b1; out_grant = 1'b1;
        push(8'h49); push(8'h0A); push(8'h8B);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = flit_valid && (flit == 8'h0A);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL t3_body_timeout: body 0a not presented within 20 cycles"); end
        out_ready = 1'b0;
        #1;
        n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL t3_rd_stall0: got %b exp 0", fifo_rd_en); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (flit !== 8'h0A || flit_valid !== 1'b1) begin n_fail++; $display("FAIL t3_hold[%0d]: flit %h valid %b exp 0a 1", i, flit, flit_valid); end
            n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL t3_rd_stall[%0d]: got %b exp 0", i, fifo_rd_en); end
        end
        n_checks++; if (xfer_n - xbase != 1) begin n_fail++; $display("FAIL t3_stalled_count: got %0d exp 1", xfer_n - xbase); end
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (xfer_n - xbase) < 3; i++) tick();
        repeat (3) tick();
        n_checks++; if (xfer_n - xbase != 3) begin n_fail++; $display("FAIL t3_count: got %0d exp 3", xfer_n - xbase); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (xfer_log[(xbase + i) % 64] !== exp_f[i]) begin n_fail++; $display("FAIL t3_order[%0d]: got %h exp %h", i, xfer_log[(xbase + i) % 64], exp_f[i]); end
        end
        out_grant = 1'b0;
    endtask

    task automatic test_grant_delay();
        int xbase;
        xbase = xfer_n;
        out_ready = 1'b1; out_grant = 1'b0;
        push(8'h44); push(8'h80);
        repeat (3) tick();
        n_checks++; if (out_req !== 5'b01000) begin n_fail++; $display("FAIL t4_req: got %b exp 01000", out_req); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (out_req !== 5'b01000 || flit_valid !== 1'b0) begin n_fail++; $display("FAIL t4_wait[%0d]: req %b valid %b exp 01000 0", i, out_req, flit_valid); end
        end
        out_grant = 1'b1;
        #1;
        n_checks++; if (flit_valid !== 1'b0) begin n_fail++; $display("FAIL t4_grant_cycle: got %b exp 0", flit_valid); end
        tick();
        n_checks++; if (flit_valid !== 1'b1 || flit !== 8'h44) begin n_fail++; $display("FAIL t4_fwd: valid %b flit %h exp 1 44", flit_valid, flit); end
        for (int i = 0; i < 20 && (xfer_n - xbase) < 2; i++) tick();
        n_checks++; if (xfer_n - xbase != 2 || xfer_log[xbase % 64] !== 8'h44 || xfer_log[(xbase + 1) % 64] !== 8'h80) begin
            n_fail++; $display("FAIL t4_xfer: count %0d first %h second %h exp 2 44 80", xfer_n - xbase, xfer_log[xbase % 64], xfer_log[(xbase + 1) % 64]);
        end
        n_checks++; if (out_req !== 5'b0) begin n_fail++; $display("FAIL t4_release: got %b exp 00000", out_req); end
        out_grant = 1'b0;
        tick();
    endtask

    task automatic test_stray();
        int xbase, dbase;
        xbase = xfer_n; dbase = drop_n;
        out_ready = 1'b1; out_grant = 1'b0;
        push(8'h03); push(8'hC0);
        repeat (2) tick();
        n_checks++; if (drop !== 1'b1) begin n_fail++; $display("FAIL t5_drop: got %b exp 1", drop); end
        n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL t5_rd_on_drop: got %b exp 1", fifo_rd_en); end
        tick();
        n_checks++; if (drop !== 1'b0) begin n_fail++; $display("FAIL t5_drop_pulse: got %b exp 0", drop); end
        repeat (2) tick();
        n_checks++; if (out_req !== 5'b10000) begin n_fail++; $display("FAIL t5_req: got %b exp 10000", out_req); end
        out_grant = 1'b1;
        for (int i = 0; i < 20 && (xfer_n - xbase) < 1; i++) tick();
        tick();
        n_checks++; if (xfer_n - xbase != 1 || xfer_log[xbase % 64] !== 8'hC0) begin n_fail++; $display("FAIL t5_xfer: count %0d flit %h exp 1 c0", xfer_n - xbase, xfer_log[xbase % 64]); end
        n_checks++; if (drop_n - dbase != 1) begin n_fail++; $display("FAIL t5_drop_count: got %0d exp 1", drop_n - dbase); end
        out_grant = 1'b0;
    endtask

    task automatic test_reset_mid();
        int xbase, dbase;
        xbase = xfer_n;
        out_ready = 1'b1; out_grant = 1'b1;
        push(8'h49); push(8'h0A); push(8'h0B); push(8'h8B);
        for (int i = 0; i < 20 && (xfer_n - xbase) < 1; i++) tick();
        n_checks++; if (xfer_n - xbase != 1 || xfer_log[xbase % 64] !== 8'h49) begin n_fail++; $display("FAIL t6_head: count %0d flit %h exp 1 49", xfer_n - xbase, xfer_log[xbase % 64]); end
        rst_ni = 1'b0;
        #1;
        n_checks++; if (out_req !== 5'b0 || flit_valid !== 1'b0 || flit !== 8'h00) begin n_fail++; $display("FAIL t6_async: req %b valid %b flit %h exp 00000 0 00", out_req, flit_valid, flit); end
        n_checks++; if (drop !== 1'b0 || fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL t6_async_rd: drop %b rd_en %b exp 0 0", drop, fifo_rd_en); end
        out_grant = 1'b0;
        tick();
        n_checks++; if (out_req !== 5'b0 || fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL t6_held: req %b rd_en %b exp 00000 0", out_req, fifo_rd_en); end
        dbase = drop_n;
        rst_ni = 1'b1;
        for (int i = 0; i < 10 && (drop_n - dbase) < 1; i++) tick();
        n_checks++; if (drop_n - dbase != 1) begin n_fail++; $display("FAIL t6_drop: got %0d exp 1", drop_n - dbase); end
        n_checks++; if (xfer_n - xbase != 1 || out_req !== 5'b0) begin n_fail++; $display("FAIL t6_no_fwd: count %0d req %b exp 1 00000", xfer_n - xbase, out_req); end
        repeat (6) tick();
        n_checks++; if (drop_n - dbase != 2 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL t6_drain: drops %0d empty %b exp 2 1", drop_n - dbase, fifo_empty); end
        n_checks++; if (underflow_n != 0) begin n_fail++; $display("FAIL underflow: got %0d exp 0", underflow_n); end
    endtask

    initial begin
        test_reset();
        test_local();
        test_east();
        test_backpressure();
        test_grant_delay();
        test_stray();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

endmodule
